turfio_aurora_link_manager: RTL

Link bring-up and recovery sequencer for the TURF↔TURFIO Aurora link, in the `init_clk_i` domain. It drives the `gt_reset_i` and `reset_i` inputs of `turfio_aurora_reset` directly upstream of that block. It monitors lane/channel status from the Aurora core, re-running the reset sequence on timeout, on link drop or on hard error. It reports link state and a saturating retry count to the TURF register space.

---
 rtl/turfio_aurora_link_manager.sv | 113 +++++++++++
 1 files changed

// File: rtl/turfio_aurora_link_manager.sv
// turfio_aurora_link_manager: bring-up/recovery sequencer driving turfio_aurora_reset from Aurora lane/channel status.
// Optional soft-error leaky bucket enabled by defining TURFIO_AURORA_LINK_SOFTERR_EN.
module turfio_aurora_link_manager #(
  parameter int GT_RESET_CYCLES  = 128,
  parameter int SYS_RESET_CYCLES = 256,
  parameter int LANE_TIMEOUT     = 1048576,
  parameter int CHANNEL_TIMEOUT  = 1048576,
  parameter int DOWN_DEBOUNCE    = 16,
  parameter int TIMER_W          = 24
) (
  input  logic       init_clk_i,
  input  logic       init_rstn_i,
  input  logic       enable_i,
  input  logic       lane_up_i,
  input  logic       channel_up_i,
  input  logic       hard_err_i,
  input  logic       soft_err_i,
  output logic       gt_reset_o,
  output logic       reset_o,
  output logic       link_up_o,
  output logic [2:0] state_o,
  output logic [7:0] retry_count_o
);
  typedef enum logic [2:0] {
    RESET_GT     = 3'd0,
    RESET_SYS    = 3'd1,
    WAIT_LANE    = 3'd2,
    WAIT_CHANNEL = 3'd3,
    UP           = 3'd4,
    HALT         = 3'd5
  } state_t;
  localparam logic [TIMER_W-1:0] GT_LAST   = TIMER_W'(GT_RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SYS_LAST  = TIMER_W'(SYS_RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LANE_LAST = TIMER_W'(LANE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] CHAN_LAST = TIMER_W'(CHANNEL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DOWN_LAST = TIMER_W'(DOWN_DEBOUNCE - 1);
  state_t state, state_n;
  logic [TIMER_W-1:0] timer, down_cnt;
  logic [7:0] retry_q;
  (* ASYNC_REG = "TRUE" *) logic [2:0] sync_a;
  (* ASYNC_REG = "TRUE" *) logic [2:0] sync_b;
  logic lane_up, channel_up, hard_err, fault, retry, trip;
  assign {hard_err, channel_up, lane_up} = sync_b;
  assign fault = hard_err | trip;
`ifdef TURFIO_AURORA_LINK_SOFTERR_EN
  logic [7:0] bucket, bucket_sat;
  logic [8:0] bucket_add;
  logic [9:0] leak_cnt;
  assign bucket_add = {1'b0, bucket} + (soft_err_i ? 9'd16 : 9'd0);
  assign bucket_sat = bucket_add[8] ? 8'hff : bucket_add[7:0];
  assign trip = bucket[7];
  // bucket only accumulates while UP; leaving UP forgets past soft errors
  always_ff @(posedge init_clk_i) begin
    if (!init_rstn_i || state != UP) begin
      bucket   <= '0;
      leak_cnt <= '0;
    end else begin
      leak_cnt <= leak_cnt + 10'd1;
      bucket   <= bucket_sat - {7'd0, leak_cnt == 10'h3ff && bucket_sat != 8'd0};
    end
  end
`else
  logic unused_soft_err;
  assign unused_soft_err = soft_err_i;
  assign trip = 1'b0;
`endif
  always_comb begin
    state_n = state;
    retry   = 1'b0;
    if (!enable_i) state_n = HALT;
    else begin
      case (state)
        HALT:         state_n = RESET_GT;
        RESET_GT:     state_n = (timer == GT_LAST) ? RESET_SYS : RESET_GT;
        RESET_SYS:    state_n = (timer == SYS_LAST) ? WAIT_LANE : RESET_SYS;
        WAIT_LANE:    if (lane_up) state_n = WAIT_CHANNEL;
                      else retry = (timer == LANE_LAST);
        WAIT_CHANNEL: if (channel_up) state_n = UP;
                      else retry = !lane_up || timer == CHAN_LAST;
        UP:           retry = fault || (!channel_up && down_cnt == DOWN_LAST);
        default:      state_n = RESET_GT;
      endcase
      if (retry) state_n = RESET_GT;
    end
  end
  always_ff @(posedge init_clk_i) begin
    if (!init_rstn_i) begin
      state         <= RESET_GT;
      timer         <= '0;
      down_cnt      <= '0;
      retry_q       <= '0;
      sync_a        <= '0;
      sync_b        <= '0;
      gt_reset_o    <= 1'b1;
      reset_o       <= 1'b1;
      link_up_o     <= 1'b0;
      state_o       <= '0;
      retry_count_o <= '0;
    end else begin
      sync_a        <= {hard_err_i, channel_up_i, lane_up_i};
      sync_b        <= sync_a;
      state         <= state_n;
      timer         <= (state_n != state) ? '0 : timer + TIMER_W'(1);
      down_cnt      <= (state == UP && !channel_up) ? down_cnt + TIMER_W'(1) : '0;
      retry_q       <= retry_q + {7'd0, retry && retry_q != 8'hff};
      gt_reset_o    <= state == RESET_GT || state == HALT;
      reset_o       <= state == RESET_GT || state == RESET_SYS || state == HALT;
      link_up_o     <= state == UP;
      state_o       <= state;
      retry_count_o <= retry_q;
    end
  end
endmodule
